// File: rtl/fp_pkg.sv
// Fixed-point number format shared by the neuron datapath blocks.
package fp;
  parameter int WORD_LENGTH = 16;
endpackage

// File: rtl/syn_current_scheduler_if.sv
// Configuration, sweep-control and shared-datapath signals of the synapse current scheduler.
// SYN_CURRENT_SCHED_SAT_EN adds the sticky saturation flag.
interface syn_current_scheduler_if #(
  parameter int NUM_SYN   = 8,
  parameter int ACC_WIDTH = 2*fp::WORD_LENGTH+1+$clog2(NUM_SYN)
);
  localparam int W  = fp::WORD_LENGTH;
  localparam int PW = 2*W+1;
  localparam int AW = $clog2(NUM_SYN);

  logic                        cfg_we;
  logic                        cfg_ready;
  logic [AW-1:0]               cfg_addr;
  logic [W-1:0]                cfg_erev;
  logic [W-1:0]                cfg_gsyn;
  logic                        cfg_en;
  logic                        start;
  logic [W-1:0]                vmem;
  logic                        busy;
  logic                        done;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [W-1:0]                dp_vmem;
  logic [W-1:0]                dp_erev;
  logic [W-1:0]                dp_gsyn;
  logic signed [PW-1:0]        dp_current;
`ifdef SYN_CURRENT_SCHED_SAT_EN
  logic                        sat;

  modport slave (
    input  cfg_we, cfg_addr, cfg_erev, cfg_gsyn, cfg_en, start, vmem, dp_current,
    output cfg_ready, busy, done, sum, sat, dp_vmem, dp_erev, dp_gsyn
  );
  modport master (
    output cfg_we, cfg_addr, cfg_erev, cfg_gsyn, cfg_en, start, vmem, dp_current,
    input  cfg_ready, busy, done, sum, sat, dp_vmem, dp_erev, dp_gsyn
  );
`else
  modport slave (
    input  cfg_we, cfg_addr, cfg_erev, cfg_gsyn, cfg_en, start, vmem, dp_current,
    output cfg_ready, busy, done, sum, dp_vmem, dp_erev, dp_gsyn
  );
  modport master (
    output cfg_we, cfg_addr, cfg_erev, cfg_gsyn, cfg_en, start, vmem, dp_current,
    input  cfg_ready, busy, done, sum, dp_vmem, dp_erev, dp_gsyn
  );
`endif
endinterface

// File: rtl/syn_current_scheduler.sv
// Sweeps NUM_SYN synapse slots through one external current datapath and sums the results.
// Optional SYN_CURRENT_SCHED_SAT_EN: saturating accumulator plus sticky sat flag.
module syn_current_scheduler #(
  parameter int NUM_SYN   = 8,
  parameter int ACC_WIDTH = 2*fp::WORD_LENGTH+1+$clog2(NUM_SYN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  syn_current_scheduler_if.slave  bus
);
  localparam int W  = fp::WORD_LENGTH;
  localparam int PW = 2*W+1;
  localparam int AW = $clog2(NUM_SYN);
  localparam logic [AW:0]   NUM_SYN_EXT = (AW+1)'(NUM_SYN);
  localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_SYN-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                      state_q, state_d;
  logic [W-1:0]                erev_q [NUM_SYN];
  logic [W-1:0]                gsyn_q [NUM_SYN];
  logic [NUM_SYN-1:0]          en_q;
  logic [AW-1:0]               idx_q;
  logic [W-1:0]                vmem_q;
  logic signed [PW-1:0]        prod_q;
  logic                        prod_v;
  logic signed [ACC_WIDTH-1:0] sum_q;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        busy;
  logic                        accept;
  logic                        cfg_hit;

  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign accept   = (state_q == IDLE) && bus.start;
  assign cfg_hit  = bus.cfg_we && !busy && ({1'b0, bus.cfg_addr} < NUM_SYN_EXT);
  assign prod_ext = ACC_WIDTH'(prod_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ISSUE;
      ISSUE:   if (idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SYN; i++) begin
        erev_q[i] <= '0;
        gsyn_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_hit) begin
      erev_q[bus.cfg_addr] <= bus.cfg_erev;
      gsyn_q[bus.cfg_addr] <= bus.cfg_gsyn;
      en_q[bus.cfg_addr]   <= bus.cfg_en;
    end
  end

`ifdef SYN_CURRENT_SCHED_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] acc_wide;
  logic               ovf;
  logic               sat_q;

  // One guard bit: a sign disagreement between the top two bits means the add overflowed.
  always_comb begin
    acc_wide = {sum_q[ACC_WIDTH-1], sum_q} + {prod_ext[ACC_WIDTH-1], prod_ext};
    ovf      = acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1];
    acc_next = acc_wide[ACC_WIDTH-1:0];
    if (ovf) acc_next = acc_wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sat_q <= 1'b0;
    else if (accept)           sat_q <= 1'b0;
    else if (prod_v && ovf)    sat_q <= 1'b1;
  end

  assign bus.sat = sat_q;
`else
  assign acc_next = sum_q + prod_ext;
`endif

  // Product register splits datapath and adder; prod_v follows the slot one edge behind idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vmem_q <= '0;
      sum_q  <= '0;
      idx_q  <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
    end else if (accept) begin
      vmem_q <= bus.vmem;
      sum_q  <= '0;
      idx_q  <= '0;
      prod_v <= 1'b0;
    end else begin
      if (prod_v) sum_q <= acc_next;
      if (state_q == ISSUE) begin
        prod_q <= bus.dp_current;
        prod_v <= en_q[idx_q];
        idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end else begin
        prod_v <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.dp_vmem = '0;
    bus.dp_erev = '0;
    bus.dp_gsyn = '0;
    if (state_q == ISSUE) begin
      bus.dp_vmem = vmem_q;
      bus.dp_erev = erev_q[idx_q];
      bus.dp_gsyn = gsyn_q[idx_q];
    end
  end

  assign bus.busy      = busy;
  assign bus.cfg_ready = !busy;
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
endmodule

// File: tb/tb_syn_current_scheduler.sv
// Scoreboard bench: stimulus pushes expected sweep results, a monitor checks each done pulse.
module tb_syn_current_scheduler;
  localparam int N   = 8;
  localparam int W   = fp::WORD_LENGTH;
  localparam int PW  = 2*W+1;
  localparam int ACC = PW;

  typedef struct {
    int                    done_cyc;
    logic signed [ACC-1:0] sum;
    bit                    sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   idle_at;
  int   busy_lo;
  int   busy_hi;
  bit   tb_done;
  exp_t sb[$];

  logic [W-1:0] erev_m [N];
  logic [W-1:0] gsyn_m [N];
  bit           en_m   [N];

  syn_current_scheduler_if #(.NUM_SYN(N), .ACC_WIDTH(ACC)) bus ();

  syn_current_scheduler #(.NUM_SYN(N), .ACC_WIDTH(ACC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational datapath: (E_rev - vmem) * gsyn, gsyn unsigned.
  assign bus.dp_current = PW'((longint'($signed(bus.dp_erev)) - longint'($signed(bus.dp_vmem)))
                              * longint'(bus.dp_gsyn));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model_sweep(input logic [W-1:0] v, input int e0);
    exp_t   e;
    longint acc = 0;
    longint smax = (longint'(1) <<< (ACC-1)) - 1;
    longint smin = -(longint'(1) <<< (ACC-1));
    e.sat = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en_m[i]) begin
        acc += (longint'($signed(erev_m[i])) - longint'($signed(v))) * longint'(gsyn_m[i]);
`ifdef SYN_CURRENT_SCHED_SAT_EN
        if (acc > smax) begin acc = smax; e.sat = 1'b1; end
        else if (acc < smin) begin acc = smin; e.sat = 1'b1; end
`endif
      end
    end
    e.sum      = ACC'(acc);
    e.done_cyc = e0 + N + 1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      erev_m[i] = '0;
      gsyn_m[i] = '0;
      en_m[i]   = 1'b0;
    end
    sb.delete();
    idle_at = 0;
    busy_lo = 1;
    busy_hi = 0;
  endtask

  // One clock edge: apply the behavioural model to the inputs sampled at that edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (bus.cfg_we && int'(bus.cfg_addr) < N && !(cyc >= busy_lo && cyc <= busy_hi)) begin
        erev_m[bus.cfg_addr] = bus.cfg_erev;
        gsyn_m[bus.cfg_addr] = bus.cfg_gsyn;
        en_m[bus.cfg_addr]   = bus.cfg_en;
      end
      if (bus.start && cyc >= idle_at) begin
        sb.push_back(model_sweep(bus.vmem, cyc));
        idle_at = cyc + N + 3;
        busy_lo = cyc + 1;
        busy_hi = cyc + N + 1;
      end
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg_write(input int a, input logic [W-1:0] e, input logic [W-1:0] g, input bit en);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = ($clog2(N))'(a);
    bus.cfg_erev = e;
    bus.cfg_gsyn = g;
    bus.cfg_en   = en;
    step();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic sweep(input logic [W-1:0] v);
    bus.start = 1'b1;
    bus.vmem  = v;
    step();
    bus.start = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    while (!tb_done) begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("sum", longint'(bus.sum), longint'(e.sum));
          chk("busy_at_done", longint'(bus.busy), 0);
`ifdef SYN_CURRENT_SCHED_SAT_EN
          chk("sat", longint'(bus.sat), longint'(e.sat));
`endif
        end
      end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
        e = sb.pop_front();
        chk("missing_done", cyc, e.done_cyc);
      end
    end
  endtask

  task automatic driver();
    rst_n        = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_erev = '0;
    bus.cfg_gsyn = '0;
    bus.cfg_en   = 1'b0;
    bus.start    = 1'b0;
    bus.vmem     = '0;
    model_reset();
    steps(3);
    rst_n = 1'b1;
    step();
    chk("reset_busy", longint'(bus.busy), 0);
    chk("reset_done", longint'(bus.done), 0);
    chk("reset_sum", longint'(bus.sum), 0);
    chk("reset_cfg_ready", longint'(bus.cfg_ready), 1);

    // All slots disabled.
    sweep(16'd123);
    steps(N + 4);

    cfg_write(3, 16'd10, 16'd5, 1'b1);
    sweep(16'd4);
    steps(3);
    chk("dp_erev_issue4", longint'(bus.dp_erev), 10);
    chk("dp_gsyn_issue4", longint'(bus.dp_gsyn), 5);
    chk("dp_vmem_issue4", longint'(bus.dp_vmem), 4);
    steps(N + 2);

    // Write while busy and start mid-sweep must both be ignored.
    cfg_write(5, 16'd2, 16'd3, 1'b1);
    sweep(16'd4);
    step();
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 3'd2;
    bus.cfg_erev = 16'd100;
    bus.cfg_gsyn = 16'd100;
    bus.cfg_en   = 1'b1;
    chk("cfg_ready_busy", longint'(bus.cfg_ready), 0);
    step();
    bus.cfg_we = 1'b0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    steps(N + 2);
    sweep(16'd4);
    steps(N + 4);
    chk("idle_dp_erev", longint'(bus.dp_erev), 0);

    // Held start: back-to-back sweeps every N+3 cycles.
    bus.start = 1'b1;
    bus.vmem  = 16'd4;
    steps(25);
    bus.start = 1'b0;
    steps(N + 4);

    // Reset in the 3rd ISSUE cycle.
    sweep(16'd4);
    steps(2);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", longint'(bus.busy), 0);
    chk("midreset_done", longint'(bus.done), 0);
    chk("midreset_sum", longint'(bus.sum), 0);
    chk("midreset_dp_gsyn", longint'(bus.dp_gsyn), 0);
    model_reset();
    steps(2);
    rst_n = 1'b1;
    step();
    cfg_write(6, 16'd9, 16'd9, 1'b0);
    sweep(16'd7);
    steps(N + 4);

    // Every slot at the largest positive product.
    for (int i = 0; i < N; i++) cfg_write(i, 16'h7fff, 16'hffff, 1'b1);
    sweep(16'h8000);
    steps(N + 4);

    for (int i = 0; i < 400; i++) begin
      bus.cfg_we   = ($urandom_range(0, 2) == 0);
      bus.cfg_addr = ($clog2(N))'($urandom);
      bus.cfg_erev = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      bus.cfg_gsyn = W'($urandom);
      bus.cfg_en   = ($urandom_range(0, 3) != 0);
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.vmem     = W'($urandom);
      step();
    end
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
    steps(N + 6);
    chk("scoreboard_empty", sb.size(), 0);
    tb_done = 1'b1;
    step();
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    cyc     = 0;
    tb_done = 1'b0;
    fork
      driver();
      monitor();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/syn_current_scheduler.md
Name: syn_current_scheduler

Overview:
- Time-multiplexes one shared synapse-to-dendrite current datapath (E_rev − vmem, times unsigned gsyn; signed product of 2*fp::WORD_LENGTH+1 bits) across NUM_SYN synapse slots of one dendritic compartment.
- Holds the per-slot configuration: E_rev, gsyn and an enable bit.
- On each start, sweeps all slots in index order and returns the signed sum of their currents to the compartment integrator.
- The datapath stays external and combinational; this block only drives it and collects its result.

Parameters:
- NUM_SYN, 8: number of synapse slots; must be at least 2.
- ACC_WIDTH, 2*fp::WORD_LENGTH+1+$clog2(NUM_SYN): accumulator and sum width; must be at least 2*fp::WORD_LENGTH+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  slot configuration write strobe.
- cfg_ready  out  1  high when a configuration write is accepted; equals !busy.
- cfg_addr  in  $clog2(NUM_SYN)  slot index to write.
- cfg_erev  in  fp::WORD_LENGTH  reversal potential written to the slot.
- cfg_gsyn  in  fp::WORD_LENGTH  conductance written to the slot; unsigned.
- cfg_en  in  1  slot enable bit.
- start  in  1  sweep request; one-cycle pulse or level.
- vmem  in  fp::WORD_LENGTH  membrane voltage, sampled on the accepted start.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse; sum is valid.
- sum  out  ACC_WIDTH  signed total current.
- dp_vmem  out  fp::WORD_LENGTH  to datapath vmem input.
- dp_erev  out  fp::WORD_LENGTH  to datapath E_rev input.
- dp_gsyn  out  fp::WORD_LENGTH  to datapath gsyn input.
- dp_current  in  2*fp::WORD_LENGTH+1  signed product from the datapath.

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0; done=0; sum=0; all slot E_rev, gsyn and enable = 0; idx=0; pipeline valid bit=0. Reset mid-sweep aborts the sweep; no done is produced.
- State IDLE:
  - cfg_ready=1.
  - cfg_we with cfg_addr<NUM_SYN writes that slot at the clock edge.
  - cfg_addr ≥ NUM_SYN: the write is ignored.
- State IDLE, start sampled high at edge E0:
  - latch vmem; clear sum to 0; idx=0; go to ISSUE; busy=1 from E0.
- State ISSUE:
  - dp_vmem = latched vmem; dp_erev = E_rev of slot idx; dp_gsyn = gsyn of slot idx. These are combinational from registers, so no glitching from primary inputs.
  - At each edge: prod_q <= dp_current; prod_v <= enable of slot idx; idx increments.
  - After the edge that samples idx=NUM_SYN−1 (edge E_NUM_SYN), go to DRAIN.
- Accumulation: at every edge where prod_v=1, sum <= sum + sign-extended prod_q. Disabled slots still take one cycle and contribute 0, so latency does not depend on the enable mask.
- State DRAIN: one cycle. At edge E(NUM_SYN+1) the last product is accumulated; go to DONE.
- State DONE: done=1 and busy=0 for exactly one cycle, then IDLE. sum holds until the next accepted start clears it.
- Latency: done is high in the cycle after edge E(NUM_SYN+1), i.e. NUM_SYN+2 cycles after start is sampled.
- start high during ISSUE, DRAIN or DONE: ignored; it is not queued.
- A held-high start in IDLE begins a new sweep immediately.
- cfg_we while busy: the write is dropped (cfg_ready=0). The sweep always uses the configuration frozen at E0.
- Outside ISSUE, dp_* outputs are driven to 0.
- Arithmetic: two's complement. Without the optional feature the accumulator wraps modulo 2^ACC_WIDTH. With the default ACC_WIDTH, overflow cannot occur.

Optional Feature:
- Macro: SYN_CURRENT_SCHED_SAT_EN.
- Defined: each accumulation saturates to the ACC_WIDTH signed range, max 2^(ACC_WIDTH−1)−1 and min −2^(ACC_WIDTH−1). Once saturated, later opposite-sign terms are applied normally from the clamped value. An additional output port sat (1 bit) is added:
  - sat is sticky for the sweep and valid with done.
  - it is cleared on start and on reset.
- Not defined: the accumulator wraps and the sat port does not exist.

Test Plan:
- Reset, then read state: busy=0, done=0, sum=0, cfg_ready=1. Start with all slots disabled -> done exactly NUM_SYN+2 cycles after start, sum=0.
- NUM_SYN=8. Slot 3 has E_rev=10, gsyn=5, enabled; vmem=4 -> sum=30. Slot 5 has E_rev=2, gsyn=3, enabled -> sum=30−6=24. dp_erev=10 during the 4th ISSUE cycle.
- Write slot 2 while busy -> cfg_ready=0, no effect on the current or the next sweep. start pulsed mid-sweep -> no second done. Write cfg_addr=9 with NUM_SYN=8 -> no slot changes.
- Assert rst_n low in the 3rd ISSUE cycle -> all outputs reset immediately, no done. Start after release -> sweep runs normally with configuration cleared to 0.
- Hold start high for 25 cycles with NUM_SYN=8 -> done pulses every 11 cycles (IDLE accept, 8 ISSUE, DRAIN, DONE), and sum is identical each time.
- SYN_CURRENT_SCHED_SAT_EN defined, ACC_WIDTH=2*fp::WORD_LENGTH+1, all slots at maximum positive product -> sum = 2^(ACC_WIDTH−1)−1 and sat=1. Without the macro -> wrapped value matches the reference model.
